// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the active-low columns, debounces whole-scan images and
// reports each newly pressed key as a single event on a valid/ready output.
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int STABLE_SCANS = 10
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int             CW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST    = CW'(SCAN_DIV - 1);
    localparam logic [7:0]     STABLE_MAX  = 8'(STABLE_SCANS);
    localparam logic [7:0]     STABLE_PREV = 8'(STABLE_SCANS - 1);

    typedef enum logic [1:0] {
        ST_START,
        ST_SCAN,
        ST_EVAL
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    colN_q, colN_d;
    logic [3:0]    rowMeta_q, rowSync_q;
    logic [15:0]   image_q, image_d;
    logic [15:0]   prevImage_q, prevImage_d;
    logic [15:0]   debImage_q, debImage_d;
    logic [7:0]    stableCnt_q, stableCnt_d;
    logic          keyValid_q, keyValid_d;
    logic [3:0]    keyCode_q, keyCode_d;
    logic          keyHeld_q, keyHeld_d;
    logic          overrun_q, overrun_d;

    logic [15:0]   newBits;
    logic [4:0]    newCount;
    logic [4:0]    keyCount;
    logic [3:0]    newIndex;
    logic          debUpdate;
    logic          eventFire;

    // Row returns are asynchronous to the clock; the idle level (all high) is the reset value.
    always_ff @(posedge clock) begin
        if (reset) begin
            rowMeta_q <= 4'hF;
            rowSync_q <= 4'hF;
        end else begin
            rowMeta_q <= row_n;
            rowSync_q <= rowMeta_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_START;
            col_q       <= 2'd0;
            cnt_q       <= '0;
            colN_q      <= 4'hF;
            image_q     <= '0;
            prevImage_q <= '0;
            debImage_q  <= '0;
            stableCnt_q <= '0;
            keyValid_q  <= 1'b0;
            keyCode_q   <= 4'd0;
            keyHeld_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            colN_q      <= colN_d;
            image_q     <= image_d;
            prevImage_q <= prevImage_d;
            debImage_q  <= debImage_d;
            stableCnt_q <= stableCnt_d;
            keyValid_q  <= keyValid_d;
            keyCode_q   <= keyCode_d;
            keyHeld_q   <= keyHeld_d;
            overrun_q   <= overrun_d;
        end
    end

    // Keys that would become newly set if the current image were accepted as debounced.
    always_comb begin
        newBits  = image_q & ~debImage_q;
        newCount = '0;
        keyCount = '0;
        newIndex = '0;
        for (int i = 0; i < 16; i++) begin
            if (newBits[i]) begin
                newCount = newCount + 5'd1;
                newIndex = 4'(i);
            end
            if (image_q[i]) begin
                keyCount = keyCount + 5'd1;
            end
        end
    end

    assign debUpdate = (state_q == ST_EVAL) && (image_q == prevImage_q) &&
                       (stableCnt_q == STABLE_PREV);
    assign eventFire = debUpdate && (newCount == 5'd1) && (keyCount <= 5'd2);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        image_d     = image_q;
        prevImage_d = prevImage_q;
        debImage_d  = debImage_q;
        stableCnt_d = stableCnt_q;
        keyValid_d  = keyValid_q;
        keyCode_d   = keyCode_q;
        overrun_d   = overrun_q;

        case (state_q)
            ST_START: begin
                col_d   = 2'd0;
                cnt_d   = '0;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d                     = '0;
                    image_d[{col_q, 2'b00} +: 4] = ~rowSync_q;
                    if (col_q == 2'd3) begin
                        state_d = ST_EVAL;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_EVAL: begin
                if (image_q == prevImage_q) begin
                    if (stableCnt_q != STABLE_MAX) begin
                        stableCnt_d = stableCnt_q + 8'd1;
                    end
                end else begin
                    stableCnt_d = '0;
                    prevImage_d = image_q;
                end
                if (debUpdate) begin
                    debImage_d = image_q;
                end
                col_d   = 2'd0;
                cnt_d   = '0;
                state_d = ST_SCAN;
            end
            default: begin
                state_d = ST_START;
            end
        endcase

        // A new press either loads (slot free or being emptied this cycle) or is dropped.
        if (eventFire) begin
            if (keyValid_q && !key_ready) begin
                overrun_d = 1'b1;
            end else begin
                keyValid_d = 1'b1;
                keyCode_d  = newIndex;
            end
        end else if (keyValid_q && key_ready) begin
            keyValid_d = 1'b0;
        end

        keyHeld_d = |debImage_d;
        colN_d    = (state_d == ST_SCAN) ? ~(4'b0001 << col_d) : 4'hF;
    end

    assign col_n     = colN_q;
    assign key_valid = keyValid_q;
    assign key_code  = keyCode_q;
    assign key_held  = keyHeld_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=8, STABLE_SCANS=3 (33-cycle scan period).
// Edge numbers count rising edges after reset release; scan n starts after edge 1+33*(n-1).
module tb_keypad_scanner;

    logic        clock;
    logic        reset;
    logic [3:0]  colN;
    logic [3:0]  rowN;
    logic        keyValid;
    logic [3:0]  keyCode;
    logic        keyReady;
    logic        keyHeld;
    logic        overrun;

    logic [15:0] keys;
    int          vectors;
    int          miscompares;
    int          edgeNum;
    int          eventCount;
    int          eventBase;

    keypad_scanner #(
        .SCAN_DIV     (8),
        .STABLE_SCANS (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .col_n     (colN),
        .row_n     (rowN),
        .key_valid (keyValid),
        .key_code  (keyCode),
        .key_ready (keyReady),
        .key_held  (keyHeld),
        .overrun   (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        rowN = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!colN[c] && keys[c*4 + r]) begin
                    rowN[r] = 1'b0;
                end
            end
        end
    end

    // Accepted transfers: key_valid & key_ready seen mid-cycle complete at the next rising edge.
    initial eventCount = 0;
    always @(negedge clock) begin
        if (!reset && keyValid && keyReady) begin
            eventCount++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            edgeNum++;
        end
    endtask

    task automatic runTo(input int target);
        while (edgeNum < target) begin
            step(1);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] k, input logic ready);
        keys     = k;
        keyReady = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h (edge %0d)",
                   tag, observed, expected, edgeNum);
        end
    endtask

    initial begin
        logic [3:0] expCol;
        vectors     = 0;
        miscompares = 0;
        edgeNum     = 0;
        reset       = 1'b1;
        applyStimulus(16'h0000, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        reset   = 1'b0;
        edgeNum = 0;

        checkOutput("rst col_n", 16'(colN), 16'hF);
        checkOutput("rst key_valid", 16'(keyValid), 16'h0);
        checkOutput("rst key_code", 16'(keyCode), 16'h0);
        checkOutput("rst key_held", 16'(keyHeld), 16'h0);
        checkOutput("rst overrun", 16'(overrun), 16'h0);

        // Idle column walk: 8 cycles per column, one all-high EVAL cycle, then col 0 again.
        for (int i = 1; i <= 34; i++) begin
            step(1);
            expCol = 4'hF;
            if (i <= 32) expCol[(i - 1) / 8] = 1'b0;
            else if (i == 34) expCol[0] = 1'b0;
            checkOutput("idle col_n", 16'(colN), 16'(expCol));
            checkOutput("idle key_valid", 16'(keyValid), 16'h0);
        end

        // Key 9 pressed at scan 2 start: event at EVAL of scan 5 (edge 166).
        eventBase = eventCount;
        applyStimulus(16'h0200, 1'b1);
        runTo(165);
        checkOutput("k9 early valid", 16'(keyValid), 16'h0);
        runTo(166);
        checkOutput("k9 valid", 16'(keyValid), 16'h1);
        checkOutput("k9 code", 16'(keyCode), 16'h9);
        checkOutput("k9 held", 16'(keyHeld), 16'h1);
        runTo(167);
        checkOutput("k9 consumed", 16'(keyValid), 16'h0);
        runTo(299);
        checkOutput("k9 single event", 16'(eventCount - eventBase), 16'h1);
        checkOutput("k9 still held", 16'(keyHeld), 16'h1);
        applyStimulus(16'h0000, 1'b1);
        runTo(429);
        checkOutput("k9 release pending", 16'(keyHeld), 16'h1);
        runTo(430);
        checkOutput("k9 released", 16'(keyHeld), 16'h0);
        checkOutput("k9 no release event", 16'(eventCount - eventBase), 16'h1);
        runTo(463);

        // Key 5 bounces for 40 cycles from scan 15 start; scan 15 samples it pressed.
        eventBase = eventCount;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(((i / 3) % 2 == 0) ? 16'h0020 : 16'h0000, 1'b1);
            step(1);
        end
        applyStimulus(16'h0020, 1'b1);
        runTo(594);
        checkOutput("k5 early valid", 16'(keyValid), 16'h0);
        checkOutput("k5 early count", 16'(eventCount - eventBase), 16'h0);
        runTo(595);
        checkOutput("k5 valid", 16'(keyValid), 16'h1);
        checkOutput("k5 code", 16'(keyCode), 16'h5);
        runTo(700);
        checkOutput("k5 single event", 16'(eventCount - eventBase), 16'h1);
        applyStimulus(16'h0000, 1'b1);
        runTo(866);
        checkOutput("k5 released", 16'(keyHeld), 16'h0);
        runTo(892);

        // Consumer stalled: key 1 loads, key 2 is dropped and flags overrun.
        applyStimulus(16'h0002, 1'b0);
        runTo(1023);
        checkOutput("k1 early valid", 16'(keyValid), 16'h0);
        runTo(1024);
        checkOutput("k1 valid", 16'(keyValid), 16'h1);
        checkOutput("k1 code", 16'(keyCode), 16'h1);
        applyStimulus(16'h0000, 1'b0);
        runTo(1156);
        checkOutput("k1 released held", 16'(keyHeld), 16'h0);
        checkOutput("k1 still pending", 16'(keyValid), 16'h1);
        applyStimulus(16'h0004, 1'b0);
        runTo(1287);
        checkOutput("ovr before", 16'(overrun), 16'h0);
        runTo(1288);
        checkOutput("ovr set", 16'(overrun), 16'h1);
        checkOutput("ovr code kept", 16'(keyCode), 16'h1);
        checkOutput("ovr valid kept", 16'(keyValid), 16'h1);
        checkOutput("ovr k2 held", 16'(keyHeld), 16'h1);
        applyStimulus(16'h0004, 1'b1);
        runTo(1289);
        checkOutput("ovr drained", 16'(keyValid), 16'h0);
        checkOutput("ovr sticky", 16'(overrun), 16'h1);
        checkOutput("ovr code after", 16'(keyCode), 16'h1);
        applyStimulus(16'h0000, 1'b1);
        runTo(1420);
        checkOutput("k2 released", 16'(keyHeld), 16'h0);

        // Keys 0 and 15 together: held but no event.
        eventBase = eventCount;
        applyStimulus(16'h8001, 1'b1);
        runTo(1551);
        checkOutput("dual not yet held", 16'(keyHeld), 16'h0);
        runTo(1552);
        checkOutput("dual held", 16'(keyHeld), 16'h1);
        checkOutput("dual no valid", 16'(keyValid), 16'h0);
        runTo(1585);
        checkOutput("dual no event", 16'(eventCount - eventBase), 16'h0);
        applyStimulus(16'h0000, 1'b1);
        runTo(1716);
        checkOutput("dual release pending", 16'(keyHeld), 16'h1);
        runTo(1717);
        checkOutput("dual released", 16'(keyHeld), 16'h0);

        // Building up: second key still reports, a third held key does not.
        eventBase = eventCount;
        applyStimulus(16'h0001, 1'b1);
        runTo(1849);
        checkOutput("k0 valid", 16'(keyValid), 16'h1);
        checkOutput("k0 code", 16'(keyCode), 16'h0);
        applyStimulus(16'h8001, 1'b1);
        runTo(1981);
        checkOutput("k15 valid", 16'(keyValid), 16'h1);
        checkOutput("k15 code", 16'(keyCode), 16'hF);
        applyStimulus(16'h8401, 1'b1);
        runTo(2113);
        checkOutput("three keys no valid", 16'(keyValid), 16'h0);
        checkOutput("three keys held", 16'(keyHeld), 16'h1);
        checkOutput("three keys count", 16'(eventCount - eventBase), 16'h2);
        applyStimulus(16'h0000, 1'b1);
        runTo(2245);
        checkOutput("three keys released", 16'(keyHeld), 16'h0);

        // Reset mid-column with a pending event; the held key re-reports after debounce.
        applyStimulus(16'h0040, 1'b0);
        runTo(2377);
        checkOutput("k6 valid", 16'(keyValid), 16'h1);
        checkOutput("k6 code", 16'(keyCode), 16'h6);
        runTo(2382);
        checkOutput("pre-rst valid", 16'(keyValid), 16'h1);
        checkOutput("pre-rst overrun", 16'(overrun), 16'h1);
        checkOutput("pre-rst col_n", 16'(colN), 16'hE);
        reset = 1'b1;
        step(1);
        checkOutput("mid-rst col_n", 16'(colN), 16'hF);
        checkOutput("mid-rst key_valid", 16'(keyValid), 16'h0);
        checkOutput("mid-rst key_code", 16'(keyCode), 16'h0);
        checkOutput("mid-rst key_held", 16'(keyHeld), 16'h0);
        checkOutput("mid-rst overrun", 16'(overrun), 16'h0);
        reset = 1'b0;
        applyStimulus(16'h0040, 1'b1);
        step(1);
        checkOutput("restart col0", 16'(colN), 16'hE);
        runTo(2392);
        checkOutput("restart col1", 16'(colN), 16'hD);
        runTo(2515);
        checkOutput("k6 re-report early", 16'(keyValid), 16'h0);
        runTo(2516);
        checkOutput("k6 re-report valid", 16'(keyValid), 16'h1);
        checkOutput("k6 re-report code", 16'(keyCode), 16'h6);
        checkOutput("k6 re-report held", 16'(keyHeld), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
